montgomery_mult: RTL and testbench

Bit-serial radix-2 Montgomery multiplier. Computes mm_out = num_1 · num_2 · 2^(−len) mod modulus, one multiplier bit per clock. Used as the core modular-multiply primitive inside the RSA modular-exponentiation datapath. A one-cycle start pulse launches an operation; a one-cycle module_end pulse reports completion.

---
 rtl/mont_step.sv | 22 ++
 rtl/montgomery_mult.sv | 86 ++++++++
 tb/tb_montgomery_mult.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mont_step.sv
// rtl/mont_step.sv - one radix-2 Montgomery iteration: (t + a_bit*b [+ n]) / 2
module mont_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] t,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] t_next
);

  logic [WIDTH+1:0] sum_ab;
  logic [WIDTH+1:0] sum_abn;

  // Adding the odd modulus makes the sum even, so the halving is exact.
  always_comb begin
    sum_ab  = t + (a_bit ? {2'b00, b} : '0);
    sum_abn = sum_ab[0] ? sum_ab + {2'b00, n} : sum_ab;
    t_next  = {1'b0, sum_abn[WIDTH+1:1]};
  end

endmodule

// File: rtl/montgomery_mult.sv
// rtl/montgomery_mult.sv - bit-serial radix-2 Montgomery multiplier, mm_out = num_1*num_2*2^-len mod modulus
module montgomery_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sig_start,
  input  logic [7:0]       len,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  input  logic [WIDTH-1:0] modulus,
  output logic             module_end,
  output logic [WIDTH-1:0] mm_out
);

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  localparam logic [7:0] WIDTH_LEN = 8'(WIDTH);

  state_t           state;
  logic [WIDTH+1:0] t_acc;
  logic [WIDTH+1:0] t_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [7:0]       len_q;
  logic [7:0]       cnt;
  logic [7:0]       len_clamped;

  assign len_clamped = (len > WIDTH_LEN) ? WIDTH_LEN : len;

  // a_q shifts right each iteration so its LSB is always the current multiplier bit.
  mont_step #(.WIDTH(WIDTH)) u_step (
    .t      (t_acc),
    .a_bit  (a_q[0]),
    .b      (b_q),
    .n      (n_q),
    .t_next (t_next)
  );

  // rstn is active-high despite its name.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= IDLE;
      module_end <= 1'b0;
      mm_out     <= '0;
      t_acc      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      n_q        <= '0;
      len_q      <= '0;
      cnt        <= '0;
    end else begin
      module_end <= 1'b0;
      case (state)
        IDLE: begin
          if (sig_start) begin
            a_q   <= num_1;
            b_q   <= num_2;
            n_q   <= modulus;
            len_q <= len_clamped;
            t_acc <= '0;
            cnt   <= '0;
            state <= (len == 8'd0) ? FINAL : CALC;
          end
        end
        CALC: begin
          t_acc <= t_next;
          a_q   <= a_q >> 1;
          cnt   <= cnt + 8'd1;
          if (cnt == len_q - 8'd1) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          // t_acc < 2N, so one conditional subtraction lands in [0, N); the low bits suffice.
          mm_out     <= (t_acc >= {2'b00, n_q}) ? t_acc[WIDTH-1:0] - n_q : t_acc[WIDTH-1:0];
          module_end <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult.sv
// tb/tb_montgomery_mult.sv - self-checking bench for montgomery_mult against a modular-arithmetic model
module tb_montgomery_mult;

  logic        clk;
  logic        rstn;
  logic        sig_start;
  logic [7:0]  len;
  logic [31:0] num_1;
  logic [31:0] num_2;
  logic [31:0] modulus;
  logic        module_end;
  logic [31:0] mm_out;

  montgomery_mult #(.WIDTH(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sig_start  (sig_start),
    .len        (len),
    .num_1      (num_1),
    .num_2      (num_2),
    .modulus    (modulus),
    .module_end (module_end),
    .mm_out     (mm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          due_a [2048];
  logic [31:0] exp_a [2048];
  logic [31:0] n_a   [2048];
  logic [31:0] exp_mm = 32'd0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // A*B*R^-1 mod N computed as (A*B mod N) times (2^-1 mod N), len times.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] n, input int l);
    logic [63:0] x;
    logic [63:0] inv2;
    int          leff;
    leff = (l > 32) ? 32 : l;
    if (leff == 0) return 32'd0;
    inv2 = ({32'd0, n} + 64'd1) >> 1;
    x = ({32'd0, a} * {32'd0, b}) % {32'd0, n};
    for (int i = 0; i < leff; i++) x = (x * inv2) % {32'd0, n};
    return x[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single compare process: completion timing, result, and mm_out hold on every cycle.
  initial forever begin
    @(negedge clk);
    if (cyc == 2) begin
      check("model_pin_rinv", 64'(model(32'd1, 32'd1, 32'd13, 4)), 64'd9);
      check("model_pin_27bit", 64'(model(32'd67676767, 32'd5962119, 32'd128255609, 27)), 64'd67676767);
    end
    if (rstn) begin
      rd_idx = wr_idx;
      exp_mm = 32'd0;
      check("reset_module_end", 64'(module_end), 64'd0);
    end else if (module_end) begin
      if (rd_idx == wr_idx) begin
        check("spurious_module_end", 64'd1, 64'd0);
      end else begin
        check("end_latency", 64'(cyc), 64'(due_a[rd_idx]));
        exp_mm = exp_a[rd_idx];
        check("result_below_n", 64'(mm_out < n_a[rd_idx]), 64'd1);
        rd_idx++;
      end
    end else if (rd_idx != wr_idx && cyc >= due_a[rd_idx]) begin
      check("missing_module_end", 64'd0, 64'd1);
      rd_idx++;
    end
    check("mm_out", 64'(mm_out), 64'(exp_mm));
  end

  // Call right after a negedge; the start is sampled on the next posedge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                          input int l, input logic [31:0] e);
    int leff;
    leff = (l > 32) ? 32 : l;
    num_1 = a;
    num_2 = b;
    modulus = n;
    len = 8'(l);
    sig_start = 1'b1;
    due_a[wr_idx] = cyc + 1 + leff + 1;
    exp_a[wr_idx] = e;
    n_a[wr_idx] = n;
    wr_idx++;
    @(negedge clk);
    sig_start = 1'b0;
    num_1 = $urandom;
    num_2 = $urandom;
    modulus = $urandom;
    len = 8'($urandom);
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (rd_idx == wr_idx) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      $display("FAIL wait_done: operation still pending after 400 cycles");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
    end
  endtask

  task automatic wait_end_pulse();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (module_end) seen = 1'b1;
    end
    if (!seen) begin
      $display("FAIL wait_end_pulse: no module_end within 400 cycles");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
    end
  endtask

  logic [31:0] rn, ra, rb;
  logic [63:0] mask;
  int          rl;

  initial begin
    rstn = 1'b1;
    sig_start = 1'b0;
    len = 8'd0;
    num_1 = 32'd0;
    num_2 = 32'd0;
    modulus = 32'd0;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);

    start_op(32'd1, 32'd1, 32'd13, 4, 32'd9);
    wait_done();
    start_op(32'd3, 32'd5, 32'd13, 4, 32'd5);
    wait_done();
    start_op(32'd67676767, 32'd5962119, 32'd128255609, 27, 32'd67676767);
    wait_done();
    start_op(32'd67676767, 32'd52525252, 32'd128255609, 27,
             model(32'd67676767, 32'd52525252, 32'd128255609, 27));
    wait_done();
    start_op(32'd5, 32'd7, 32'd13, 0, 32'd0);
    wait_done();
    start_op(32'd1, 32'd1, 32'd13, 40, model(32'd1, 32'd1, 32'd13, 32));
    wait_done();

    // Re-pulse while busy: must be ignored.
    start_op(32'd67676767, 32'd5962119, 32'd128255609, 27, 32'd67676767);
    repeat (5) @(negedge clk);
    num_1 = 32'd1;
    num_2 = 32'd1;
    modulus = 32'd13;
    len = 8'd4;
    sig_start = 1'b1;
    @(negedge clk);
    sig_start = 1'b0;
    wait_done();

    // Reset mid-CALC aborts the operation, then a fresh start completes.
    start_op(32'd3, 32'd5, 32'd128255609, 27, model(32'd3, 32'd5, 32'd128255609, 27));
    repeat (8) @(negedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b0;
    repeat (40) @(negedge clk);
    start_op(32'd3, 32'd5, 32'd13, 4, 32'd5);
    wait_done();

    // Back-to-back: restart in the IDLE cycle where module_end is high.
    start_op(32'd1, 32'd1, 32'd13, 4, 32'd9);
    wait_end_pulse();
    start_op(32'd67676767, 32'd5962119, 32'd128255609, 27, 32'd67676767);
    wait_done();

    for (int k = 0; k < 1000; k++) begin
      rl = $urandom_range(1, 32);
      mask = (64'd1 << rl) - 64'd1;
      rn = 32'({32'd0, $urandom} & mask) | 32'd1;
      ra = $urandom % rn;
      rb = $urandom % rn;
      start_op(ra, rb, rn, rl, model(ra, rb, rn, rl));
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
